arbiter_n_enq: RTL and testbench
================================

# arbiter_n_enq

Parametrised, registered enqueue arbiter for the ring-node input stage. It steers each incoming message to one of NUM_FIFO destination FIFOs, such as pass req/rep and IN_local req/rep. The destination is taken from the head flit and held for the whole message until the tail flit. It adds a one-entry output register, backpressure from FIFO full flags, and message-level locking, which the previous 4-way combinational version lacked.

## Interface
Parameters:
- FLIT_W, 16, flit data width.
- NUM_FIFO, 4, number of destination FIFOs (2..16).
- SEL_W, 2, width of dest_fifo; must satisfy 2^SEL_W >= NUM_FIFO.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flit  in  FLIT_W  incoming flit.
- ctrl  in  2  flit type: 00 idle, 01 head, 10 body, 11 tail.
- en_dest_fifo  in  1  dest_fifo is valid; required on a head flit.
- dest_fifo  in  SEL_W  destination index for a head flit.
- in_ready  out  1  block can accept a flit this cycle.
- fifo_full  in  NUM_FIFO  per-FIFO full flags.
- flit_out  out  FLIT_W  registered flit, shared by all FIFOs.
- ctrl_out  out  2  registered ctrl, shared by all FIFOs.
- en_fifo  out  NUM_FIFO  one-hot write enable to the selected FIFO tail.
- busy  out  1  a message is in progress (LOCKED state).
- err  out  1  sticky protocol error. Present only with ARB_ENQ_ERRCHK_EN; otherwise tied to 0.

## Operation
- States: IDLE and LOCKED. Registers: lock_dest (SEL_W), out_valid, out_dest, flit_out, ctrl_out.
- Offered flit: any cycle with ctrl != 00. Accepted when offered, in_ready=1, and the rule for the current state below passes.
- IDLE:
  - Head (01) with en_dest_fifo=1 and dest_fifo < NUM_FIFO: accepted. dest_fifo is latched into lock_dest; go to LOCKED.
  - Tail (11) with en_dest_fifo=1: accepted as a single-flit message; stay in IDLE.
  - Any other offered flit, or dest_fifo >= NUM_FIFO: dropped (not accepted).
- LOCKED:
  - Body (10): accepted and routed to lock_dest; dest_fifo and en_dest_fifo are ignored.
  - Tail (11): accepted and routed to lock_dest; return to IDLE.
  - Head (01): dropped; state is unchanged.
- Accepted flit: loaded into the output register with out_dest equal to the resolved destination.
- en_fifo[i] = out_valid & (out_dest==i) & ~fifo_full[i].
- Output register drains when en_fifo is nonzero.
- in_ready = ~out_valid | ~fifo_full[out_dest]. A drain and a new load in the same cycle is allowed, giving full throughput.
- busy = (state==LOCKED).
- Flits are never reordered or duplicated. Exactly one en_fifo bit is high at most.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, out_valid=0, en_fifo=0, flit_out=0, ctrl_out=00, in_ready=1, busy=0, err=0. Reset during a message discards the message; the next head starts clean.
- Latency: a flit accepted at edge N is presented with en_fifo asserted in cycle N+1 if the target is not full.
- Full target: output holds flit_out, ctrl_out and out_dest stable, en_fifo=0, in_ready=0. It drains in the first cycle fifo_full[out_dest]=0.
- Full flags of non-target FIFOs have no effect.
- Tail accepted at edge N: busy drops after edge N. A new head is accepted at edge N+1.

## Configuration
- ARB_ENQ_ERRCHK_EN defined: err is set, and held until reset, by any dropped offered flit. Cases:
  - body or tail in IDLE without en_dest_fifo;
  - head in LOCKED;
  - out-of-range dest_fifo on a head.
- Not defined: violating flits are silently dropped, err is constant 0, and no error logic is synthesised.

## Test plan
- Defaults, no full flags. Head 0x0001 to dest 0, body 0x0002 with dest_fifo=3, tail 0x0003. Required: en_fifo=0001 on three consecutive cycles with flit_out 0x0001/0x0002/0x0003; busy falls after the tail.
- Single tail flit 0x1234 with en_dest_fifo=1 and dest_fifo=2. Required: one cycle of en_fifo=0100, ctrl_out=11, busy stays 0.
- Head to dest 1 with fifo_full[1]=1 for 3 cycles. Required: en_fifo=0 and in_ready=0 for those cycles, flit held; the write occurs in the cycle full drops. fifo_full[0] toggling meanwhile has no effect.
- Head 0x4321 offered with en_dest_fifo=0 in IDLE. Required: no en_fifo pulse, state stays IDLE. With ARB_ENQ_ERRCHK_EN, err=1 and stays set.
- Head to dest 3, body, then rst pulsed low mid-message. Required: en_fifo=0 and busy=0 immediately; a following head to dest 2 is written to FIFO 2.
- Back-to-back 8-flit message with no backpressure. Required: 8 consecutive en_fifo pulses, in_ready constantly 1.

Source files
------------

// File: rtl/arbiter_n_enq.sv
// Registered enqueue arbiter: steers whole messages (head..tail) to one of NUM_FIFO FIFOs.
// Optional sticky protocol-error flag is built only when ARB_ENQ_ERRCHK_EN is defined.
module arbiter_n_enq #(
  parameter int FLIT_W   = 16,
  parameter int NUM_FIFO = 4,
  parameter int SEL_W    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [FLIT_W-1:0]   flit,
  input  logic [1:0]          ctrl,
  input  logic                en_dest_fifo,
  input  logic [SEL_W-1:0]    dest_fifo,
  output logic                in_ready,
  input  logic [NUM_FIFO-1:0] fifo_full,
  output logic [FLIT_W-1:0]   flit_out,
  output logic [1:0]          ctrl_out,
  output logic [NUM_FIFO-1:0] en_fifo,
  output logic                busy,
  output logic                err
);

  localparam logic [1:0] CTRL_IDLE = 2'b00;
  localparam logic [1:0] CTRL_HEAD = 2'b01;
  localparam logic [1:0] CTRL_BODY = 2'b10;
  localparam logic [1:0] CTRL_TAIL = 2'b11;
  localparam logic [SEL_W:0] NUM_FIFO_W = (SEL_W+1)'(NUM_FIFO);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   lock_dest;
  logic [SEL_W-1:0]   out_dest;
  logic [SEL_W-1:0]   acc_dest;
  logic               out_valid;
  logic               offered;
  logic               in_range;
  logic               accept;
  logic               load_lock;
  logic               target_full;
  logic               drain;

  // Handshake: a flit transfers on a rising edge when ctrl != 00 and in_ready = 1;
  // the output register transfers to FIFO i when en_fifo[i] = 1 (i.e. not full).
  assign offered  = (ctrl != CTRL_IDLE);
  assign in_range = ({1'b0, dest_fifo} < NUM_FIFO_W);
  assign busy     = (state == LOCKED);

  always_comb begin
    target_full = 1'b0;
    en_fifo     = '0;
    for (int i = 0; i < NUM_FIFO; i++) begin
      if (out_dest == SEL_W'(i)) begin
        target_full = fifo_full[i];
        en_fifo[i]  = out_valid & ~fifo_full[i];
      end
    end
  end

  assign drain    = |en_fifo;
  assign in_ready = ~out_valid | ~target_full;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    load_lock = 1'b0;
    acc_dest  = lock_dest;
    if (offered && in_ready) begin
      case (state)
        IDLE: begin
          if ((ctrl == CTRL_HEAD || ctrl == CTRL_TAIL) && en_dest_fifo && in_range) begin
            accept   = 1'b1;
            acc_dest = dest_fifo;
            if (ctrl == CTRL_HEAD) begin
              load_lock = 1'b1;
              state_nxt = LOCKED;
            end
          end
        end
        LOCKED: begin
          // Destination stays pinned to the head's choice; dest_fifo is ignored here.
          if (ctrl == CTRL_BODY || ctrl == CTRL_TAIL) begin
            accept = 1'b1;
            if (ctrl == CTRL_TAIL) state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lock_dest <= '0;
      out_valid <= 1'b0;
      out_dest  <= '0;
      flit_out  <= '0;
      ctrl_out  <= CTRL_IDLE;
    end else begin
      state <= state_nxt;
      if (load_lock) lock_dest <= dest_fifo;
      // A load in the same cycle as a drain simply overwrites the slot.
      if (accept) begin
        out_valid <= 1'b1;
        out_dest  <= acc_dest;
        flit_out  <= flit;
        ctrl_out  <= ctrl;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef ARB_ENQ_ERRCHK_EN
  logic drop;
  logic err_q;

  assign drop = offered & in_ready & ~accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      err_q <= 1'b0;
    else if (drop) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_arbiter_n_enq.sv
// Bench for arbiter_n_enq: directed test-plan steps followed by random traffic,
// all outputs compared each cycle against a message-level reference model.
module tb_arbiter_n_enq;

  localparam int FLIT_W   = 16;
  localparam int NUM_FIFO = 4;
  localparam int SEL_W    = 2;
  localparam int W        = 4 + 2 + FLIT_W;

  logic                clk;
  logic                rst;
  logic [FLIT_W-1:0]   flit;
  logic [1:0]          ctrl;
  logic                en_dest_fifo;
  logic [SEL_W-1:0]    dest_fifo;
  logic                in_ready;
  logic [NUM_FIFO-1:0] fifo_full;
  logic [FLIT_W-1:0]   flit_out;
  logic [1:0]          ctrl_out;
  logic [NUM_FIFO-1:0] en_fifo;
  logic                busy;
  logic                err;

  arbiter_n_enq #(.FLIT_W(FLIT_W), .NUM_FIFO(NUM_FIFO), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst(rst), .flit(flit), .ctrl(ctrl), .en_dest_fifo(en_dest_fifo),
    .dest_fifo(dest_fifo), .in_ready(in_ready), .fifo_full(fifo_full),
    .flit_out(flit_out), .ctrl_out(ctrl_out), .en_fifo(en_fifo), .busy(busy), .err(err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model: message lock plus one pending write
  logic [W-1:0] exp_q[$];
  bit  m_busy;
  int  m_lock;
  bit  m_valid;
  int  m_dest;
  bit  m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy  = 0;
    m_lock  = 0;
    m_valid = 0;
    m_dest  = 0;
    m_err   = 0;
    exp_q.delete();
  endtask

  // One clock: check outputs at negedge, predict, then advance past posedge.
  task automatic step();
    bit wr, rdy, acc, drop;
    int ad, idx;
    logic [1:0] c;
    logic [FLIT_W-1:0] f;
    @(negedge clk);
    wr  = m_valid && !fifo_full[m_dest];
    rdy = !m_valid || !fifo_full[m_dest];
    chk("en_fifo", 32'(en_fifo), wr ? (32'd1 << m_dest) : 32'd0);
    chk("in_ready", 32'(in_ready), 32'(rdy));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("err", 32'(err), 32'(m_err));
    if (en_fifo != 0) begin
      idx = 0;
      for (int i = 0; i < NUM_FIFO; i++) if (en_fifo[i]) idx = i;
      chk("sb_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("sb_write", 32'({4'(idx), ctrl_out, flit_out}), 32'(exp_q.pop_front()));
    end
    c = ctrl; f = flit; acc = 0; drop = 0; ad = 0;
    if (c != 2'b00 && rdy) begin
      if (!m_busy) begin
        if ((c == 2'b01 || c == 2'b11) && en_dest_fifo && int'(dest_fifo) < NUM_FIFO) begin
          acc = 1; ad = int'(dest_fifo);
        end
      end else if (c == 2'b10 || c == 2'b11) begin
        acc = 1; ad = m_lock;
      end
      drop = !acc;
    end
    @(posedge clk);
    #1;
    if (acc) begin
      m_valid = 1;
      m_dest  = ad;
      exp_q.push_back({4'(ad), c, f});
      if (!m_busy && c == 2'b01) begin m_busy = 1; m_lock = ad; end
      else if (m_busy && c == 2'b11) m_busy = 0;
    end else if (wr) begin
      m_valid = 0;
    end
`ifdef ARB_ENQ_ERRCHK_EN
    if (drop) m_err = 1;
`else
    if (drop) m_err = 0;
`endif
  endtask

  // driver
  task automatic send(input logic [1:0] c, input logic [FLIT_W-1:0] f,
                      input logic en, input logic [SEL_W-1:0] d);
    ctrl = c; flit = f; en_dest_fifo = en; dest_fifo = d;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; ctrl = 2'b00; flit = '0; en_dest_fifo = 1'b0; dest_fifo = '0; fifo_full = '0;
    model_reset();
    #2;
    chk("rst_en_fifo", 32'(en_fifo), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flit_out", 32'(flit_out), 32'd0);
    chk("rst_ctrl_out", 32'(ctrl_out), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // three-flit message to FIFO 0, body's dest_fifo ignored
    send(2'b01, 16'h0001, 1'b1, 2'd0);
    chk("m1_en0", 32'(en_fifo), 32'b0001); chk("m1_f0", 32'(flit_out), 32'h0001); chk("m1_busy0", 32'(busy), 32'd1);
    send(2'b10, 16'h0002, 1'b1, 2'd3);
    chk("m1_en1", 32'(en_fifo), 32'b0001); chk("m1_f1", 32'(flit_out), 32'h0002);
    send(2'b11, 16'h0003, 1'b0, 2'd0);
    chk("m1_en2", 32'(en_fifo), 32'b0001); chk("m1_f2", 32'(flit_out), 32'h0003); chk("m1_busy2", 32'(busy), 32'd0);
    send(2'b00, 16'h0000, 1'b0, 2'd0);
    chk("m1_idle", 32'(en_fifo), 32'd0);

    // single-flit message
    send(2'b11, 16'h1234, 1'b1, 2'd2);
    chk("st_en", 32'(en_fifo), 32'b0100); chk("st_ctrl", 32'(ctrl_out), 32'b11);
    chk("st_flit", 32'(flit_out), 32'h1234); chk("st_busy", 32'(busy), 32'd0);
    send(2'b00, 16'h0000, 1'b0, 2'd0);

    // target full for three cycles, non-target full flag toggling
    fifo_full = 4'b0010;
    send(2'b01, 16'h00f1, 1'b1, 2'd1);
    ctrl = 2'b00;
    for (int k = 0; k < 3; k++) begin
      chk("bp_en", 32'(en_fifo), 32'd0); chk("bp_rdy", 32'(in_ready), 32'd0);
      chk("bp_flit", 32'(flit_out), 32'h00f1);
      fifo_full[0] = ~fifo_full[0];
      if (k < 2) step();
    end
    fifo_full = 4'b0000;
    #1;
    chk("bp_release", 32'(en_fifo), 32'b0010);
    send(2'b11, 16'h00f2, 1'b0, 2'd0);
    send(2'b00, 16'h0000, 1'b0, 2'd0);

    // head without en_dest_fifo is dropped
    send(2'b01, 16'h4321, 1'b0, 2'd1);
    chk("drop_en", 32'(en_fifo), 32'd0); chk("drop_busy", 32'(busy), 32'd0);
    send(2'b00, 16'h0000, 1'b0, 2'd0);
`ifdef ARB_ENQ_ERRCHK_EN
    chk("drop_err", 32'(err), 32'd1);
`else
    chk("drop_err", 32'(err), 32'd0);
`endif

    // reset mid-message
    send(2'b01, 16'h0031, 1'b1, 2'd3);
    send(2'b10, 16'h0032, 1'b0, 2'd0);
    ctrl = 2'b00;
    rst = 1'b0;
    #1;
    chk("mr_en", 32'(en_fifo), 32'd0); chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_rdy", 32'(in_ready), 32'd1); chk("mr_err", 32'(err), 32'd0);
    model_reset();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    send(2'b01, 16'h00aa, 1'b1, 2'd2);
    chk("mr_head", 32'(en_fifo), 32'b0100); chk("mr_hflit", 32'(flit_out), 32'h00aa);
    send(2'b11, 16'h00ab, 1'b1, 2'd0);
    send(2'b00, 16'h0000, 1'b0, 2'd0);

    // back-to-back eight-flit message
    for (int k = 0; k < 8; k++) begin
      chk("b2b_rdy", 32'(in_ready), 32'd1);
      send((k == 0) ? 2'b01 : ((k == 7) ? 2'b11 : 2'b10), 16'(16'h0b00 + k), 1'b1, 2'd2);
      chk("b2b_en", 32'(en_fifo), 32'b0100);
      chk("b2b_flit", 32'(flit_out), 32'(16'h0b00 + k));
    end
    send(2'b00, 16'h0000, 1'b0, 2'd0);
    chk("b2b_after", 32'(en_fifo), 32'd0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NUM_FIFO; i++) fifo_full[i] = ($urandom_range(0, 3) == 0);
      send(2'($urandom_range(0, 3)), 16'($urandom), ($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)));
    end
    fifo_full = '0;
    for (int n = 0; n < 3; n++) send(2'b00, 16'h0000, 1'b0, 2'd0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
